body_pixel_mapper: RTL and testbench

- Downstream of the n-body engine. After the engine raises done, this block walks the x/y position RAMs (read-only port) for bodies 0..num_bodies-1.
- It converts each IEEE-754 binary64 coordinate to an on-screen integer pixel and streams the (idx, px, py) records over a valid/ready handshake to the display sprite buffer.
- Off-screen, NaN and Inf bodies are dropped and counted.

---
 rtl/body_pixel_mapper_if.sv | 28 ++
 rtl/body_pixel_mapper.sv | 206 ++++++++++++++++++++
 tb/tb_body_pixel_mapper.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/body_pixel_mapper_if.sv
`default_nettype none
// ============================================================================
// Module   : body_pixel_mapper_if
// Purpose  : Valid/ready record stream (idx, px, py, last) to the sprite buffer.
// Revision : 1.0
// ============================================================================
interface body_pixel_mapper_if #(
    parameter int ADDR_W = 9,
    parameter int PIX_W  = 10
) ();
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_idx;
    logic [PIX_W-1:0]  out_px;
    logic [PIX_W-1:0]  out_py;
    logic              out_last;

    modport master (
        output out_valid, out_idx, out_px, out_py, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_idx, out_px, out_py, out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/body_pixel_mapper.sv
`default_nettype none
// ============================================================================
// Module   : body_pixel_mapper
// Purpose  : Scans binary64 body positions and streams on-screen pixel records.
// Revision : 1.0
// ============================================================================
module body_pixel_mapper #(
    parameter int BODIES          = 512,
    parameter int DATA_WIDTH      = 64,
    parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
    parameter int SCREEN_W        = 640,
    parameter int SCREEN_H        = 480,
    parameter int PIX_W           = 10,
    parameter int SCALE_SHIFT     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BODY_ADDR_WIDTH-1:0] num_bodies,
    output logic [BODY_ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0]      ram_x,
    input  logic [DATA_WIDTH-1:0]      ram_y,
    body_pixel_mapper_if.master        rec,
    output logic                       busy,
    output logic                       done,
    output logic [BODY_ADDR_WIDTH:0]   drop_count
);

    localparam int                     c_BIAS = 1023 + SCALE_SHIFT;
    localparam logic signed [PIX_W+1:0] c_CX  = (PIX_W+2)'(SCREEN_W / 2);
    localparam logic signed [PIX_W+1:0] c_CY  = (PIX_W+2)'(SCREEN_H / 2);
    localparam logic signed [PIX_W+1:0] c_XMAX = (PIX_W+2)'(SCREEN_W - 1);
    localparam logic signed [PIX_W+1:0] c_YMAX = (PIX_W+2)'(SCREEN_H - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_CONV  = 3'd3,
        S_EMIT  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [BODY_ADDR_WIDTH-1:0] r_num;
    logic [BODY_ADDR_WIDTH-1:0] r_idx;
    logic [BODY_ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]      r_x;
    logic [DATA_WIDTH-1:0]      r_y;
    logic                       r_valid;
    logic [BODY_ADDR_WIDTH-1:0] r_out_idx;
    logic [PIX_W-1:0]           r_px;
    logic [PIX_W-1:0]           r_py;
    logic                       r_last;
    logic                       r_busy;
    logic                       r_done;
    logic [BODY_ADDR_WIDTH:0]   r_drop;

    logic [PIX_W+2:0]           w_cx;
    logic [PIX_W+2:0]           w_cy;
    logic signed [PIX_W+1:0]    w_vx;
    logic signed [PIX_W+1:0]    w_vy;
    logic signed [PIX_W+1:0]    w_px;
    logic signed [PIX_W+1:0]    w_py;
    logic                       w_ok;
    logic                       w_is_last;
    logic                       w_hs;
    logic [BODY_ADDR_WIDTH-1:0] w_idx_inc;

    // Returns {ok, signed value}; magnitude is truncated toward zero.
    function automatic logic [PIX_W+2:0] conv_word(input logic [DATA_WIDTH-1:0] d);
        logic [10:0]      ex;
        logic [52:0]      sig;
        logic [PIX_W+1:0] mag;
        logic             ok;
        int               e;
        ex  = d[62:52];
        sig = {1'b1, d[51:0]};
        e   = int'(ex) - c_BIAS;
        mag = '0;
        ok  = 1'b1;
        if (ex == 11'h7FF) begin
            ok = 1'b0;
        end else if (ex != 11'd0 && e > PIX_W) begin
            ok = 1'b0;
        end else if (ex != 11'd0 && e >= 0) begin
            sig = sig >> (52 - e);
            mag = {1'b0, sig[PIX_W:0]};
        end
        return {ok, (d[DATA_WIDTH-1] ? -mag : mag)};
    endfunction

    always_comb begin
        w_cx      = conv_word(r_x);
        w_cy      = conv_word(r_y);
        w_vx      = $signed(w_cx[PIX_W+1:0]);
        w_vy      = $signed(w_cy[PIX_W+1:0]);
        w_px      = w_vx + c_CX;
        w_py      = c_CY - w_vy;
        w_ok      = w_cx[PIX_W+2] && w_cy[PIX_W+2] &&
                    !w_px[PIX_W+1] && (w_px <= c_XMAX) &&
                    !w_py[PIX_W+1] && (w_py <= c_YMAX);
        w_is_last = (r_idx == r_num - 1'b1);
        w_hs      = r_valid && rec.out_ready;
        w_idx_inc = r_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (num_bodies == '0) ? S_FIN : S_READ;
            S_READ:  w_next = S_LATCH;
            S_LATCH: w_next = S_CONV;
            S_CONV:  w_next = w_ok ? S_EMIT : (w_is_last ? S_FIN : S_READ);
            S_EMIT:  if (w_hs) w_next = w_is_last ? S_FIN : S_READ;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ram_addr is loaded on entry to READ so the RAM word lands during LATCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num     <= '0;
            r_idx     <= '0;
            r_addr    <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_valid   <= 1'b0;
            r_out_idx <= '0;
            r_px      <= '0;
            r_py      <= '0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_drop    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num  <= num_bodies;
                        r_idx  <= '0;
                        r_addr <= '0;
                        r_drop <= '0;
                        r_busy <= 1'b1;
                    end
                end
                S_LATCH: begin
                    r_x <= ram_x;
                    r_y <= ram_y;
                end
                S_CONV: begin
                    if (w_ok) begin
                        r_valid   <= 1'b1;
                        r_out_idx <= r_idx;
                        r_px      <= w_px[PIX_W-1:0];
                        r_py      <= w_py[PIX_W-1:0];
                        r_last    <= w_is_last;
                    end else begin
                        if (r_drop != '1) r_drop <= r_drop + 1'b1;
                        if (!w_is_last) begin
                            r_idx  <= w_idx_inc;
                            r_addr <= w_idx_inc;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        if (!w_is_last) begin
                            r_idx  <= w_idx_inc;
                            r_addr <= w_idx_inc;
                        end
                    end
                end
                S_FIN: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign ram_addr      = r_addr;
    assign rec.out_valid = r_valid;
    assign rec.out_idx   = r_out_idx;
    assign rec.out_px    = r_px;
    assign rec.out_py    = r_py;
    assign rec.out_last  = r_last;
    assign busy          = r_busy;
    assign done          = r_done;
    assign drop_count    = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_body_pixel_mapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_body_pixel_mapper
// Purpose  : Randomised and directed bench with a real-arithmetic pixel model.
// Revision : 1.0
// ============================================================================
module tb_body_pixel_mapper;
    localparam int  AW = 9;
    localparam int  PW = 10;
    localparam int  NB = 512;
    localparam real LIMIT = 2048.0;

    typedef struct {
        int idx;
        int px;
        int py;
        bit last;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] num_bodies;
    logic [AW-1:0] ram_addr;
    logic [63:0]   ram_x;
    logic [63:0]   ram_y;
    logic          busy;
    logic          done;
    logic [AW:0]   drop_count;

    body_pixel_mapper_if #(.ADDR_W(AW), .PIX_W(PW)) rec_if ();

    body_pixel_mapper #(
        .BODIES(NB), .DATA_WIDTH(64), .BODY_ADDR_WIDTH(AW),
        .SCREEN_W(640), .SCREEN_H(480), .PIX_W(PW), .SCALE_SHIFT(0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_bodies(num_bodies),
        .ram_addr(ram_addr), .ram_x(ram_x), .ram_y(ram_y), .rec(rec_if),
        .busy(busy), .done(done), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    logic [63:0] mem_x [NB];
    logic [63:0] mem_y [NB];
    always @(posedge clk) begin
        ram_x <= mem_x[ram_addr];
        ram_y <= mem_y[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    rec_t exp_q[$];
    int   exp_drop, exp_count;
    int   first_valid_edge, done_edge, hs_count, done_count = 0, t_start;
    bit   prev_v = 0, prev_hs = 0, prev_done = 0, f_got;
    int   f_idx, f_px, f_py, f_last;
    int   s_idx, s_px, s_py, s_last;
    int   ready_mode = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit model_coord(input logic [63:0] d, output int v);
        real r, a;
        r = $bitstoreal(d);
        a = (r < 0.0) ? -r : r;
        v = 0;
        if (!(a < LIMIT)) return 1'b0;
        v = $rtoi(r);
        return 1'b1;
    endfunction

    function automatic bit model_body(input logic [63:0] x, input logic [63:0] y,
                                      output int px, output int py);
        int vx, vy;
        bit okx, oky;
        okx = model_coord(x, vx);
        oky = model_coord(y, vy);
        px  = vx + 320;
        py  = 240 - vy;
        return okx && oky && px >= 0 && px <= 639 && py >= 0 && py <= 479;
    endfunction

    function automatic logic [63:0] rand_coord(input bit is_x);
        real r, span;
        int  k;
        int  xt[4];
        int  yt[4];
        xt   = '{-321, -320, 319, 320};
        yt   = '{-241, -240, 239, 240};
        span = is_x ? 700.0 : 520.0;
        case ($urandom_range(0, 11))
            0: return {1'b0, 11'h7FF, 1'b1, 51'($urandom)};
            1: return {1'($urandom), 11'h7FF, 52'd0};
            2: begin
                r = 2048.0 + real'($urandom_range(0, 100000));
                if ($urandom_range(0, 1) == 1) r = -r;
                return $realtobits(r);
            end
            3: return {1'($urandom), 11'd0, 20'($urandom), 32'($urandom)};
            4, 5: begin
                k = int'($urandom_range(0, 3));
                r = real'(is_x ? xt[k] : yt[k]);
                if ($urandom_range(0, 1) == 1) r = r + ((r < 0.0) ? -0.5 : 0.5);
                return $realtobits(r);
            end
            default: begin
                r = (real'($urandom_range(0, 2000000)) / 1000000.0 - 1.0) * span;
                return $realtobits(r);
            end
        endcase
    endfunction

    task automatic load_scan(input int n);
        int px, py;
        exp_q.delete();
        exp_drop  = 0;
        exp_count = 0;
        for (int i = 0; i < n; i++) begin
            if (model_body(mem_x[i], mem_y[i], px, py)) begin
                exp_q.push_back('{i, px, py, (i == n - 1)});
                exp_count++;
            end else begin
                exp_drop++;
            end
        end
        first_valid_edge = -1;
        done_edge        = -1;
        hs_count         = 0;
        f_got            = 0;
    endtask

    task automatic do_start(input int n);
        @(posedge clk); #1;
        start      = 1'b1;
        num_bodies = AW'(n);
        @(posedge clk); #1;
        t_start = cyc;
        start   = 1'b0;
    endtask

    task automatic wait_done(input int tgt, input int limit);
        for (int k = 0; k < limit; k++) begin
            if (done_count >= tgt) break;
            @(posedge clk);
        end
        #1;
        check("done_seen", (done_count >= tgt) ? 1 : 0, 1);
    endtask

    initial begin
        rec_if.out_ready = 1'b0;
        forever begin
            int st;
            @(posedge clk); #1;
            case (ready_mode)
                0: rec_if.out_ready = 1'b1;
                1: rec_if.out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (!rec_if.out_valid) begin
                        rec_if.out_ready = 1'b0;
                        st = 0;
                    end else if (st < 5) begin
                        rec_if.out_ready = 1'b0;
                        st++;
                    end else begin
                        rec_if.out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Scoreboard: record order/content, hold-while-stalled, done/drop_count.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_v && !prev_hs) begin
                check("valid_held", rec_if.out_valid, 1);
                check("idx_stable", rec_if.out_idx, s_idx);
                check("px_stable", rec_if.out_px, s_px);
                check("py_stable", rec_if.out_py, s_py);
                check("last_stable", rec_if.out_last, s_last);
            end
            if (rec_if.out_valid) begin
                if (first_valid_edge < 0) first_valid_edge = cyc + 1;
                if (rec_if.out_ready) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_record_idx", rec_if.out_idx, -1);
                    end else begin
                        rec_t e;
                        e = exp_q.pop_front();
                        check("rec_idx", rec_if.out_idx, e.idx);
                        check("rec_px", rec_if.out_px, e.px);
                        check("rec_py", rec_if.out_py, e.py);
                        check("rec_last", rec_if.out_last, e.last);
                        if (!f_got) begin
                            f_got  = 1;
                            f_idx  = rec_if.out_idx;
                            f_px   = rec_if.out_px;
                            f_py   = rec_if.out_py;
                            f_last = rec_if.out_last;
                        end
                    end
                end
            end
            s_idx   = rec_if.out_idx;
            s_px    = rec_if.out_px;
            s_py    = rec_if.out_py;
            s_last  = rec_if.out_last;
            prev_v  = rec_if.out_valid;
            prev_hs = rec_if.out_valid && rec_if.out_ready;
            if (done) begin
                done_count++;
                done_edge = cyc + 1;
                check("done_single", prev_done, 0);
                check("drop_count", drop_count, exp_drop);
                check("records_left", exp_q.size(), 0);
            end
            prev_done = done;
        end
    end

    initial begin
        int  px, py, dc, n;
        bit  ok, found;
        rst        = 1'b1;
        start      = 1'b0;
        num_bodies = '0;
        for (int i = 0; i < NB; i++) begin
            mem_x[i] = '0;
            mem_y[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", rec_if.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_drop", drop_count, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_idx", rec_if.out_idx, 0);
        check("rst_px", rec_if.out_px, 0);
        check("rst_py", rec_if.out_py, 0);
        check("rst_last", rec_if.out_last, 0);
        rst = 1'b0;

        // Hand-derived values that pin the model itself.
        ok = model_body(64'hC05932CCCCCCCCCD, $realtobits(50.9), px, py);
        check("pin_trunc_ok", ok, 1); check("pin_trunc_px", px, 220); check("pin_trunc_py", py, 190);
        ok = model_body(64'h8000000000000000, $realtobits(239.99), px, py);
        check("pin_neg0_px", px, 320); check("pin_neg0_py", py, 1);
        ok = model_body($realtobits(400.0), 64'd0, px, py);
        check("pin_offx_ok", ok, 0);
        ok = model_body(64'h7FF8000000000000, 64'd0, px, py);
        check("pin_nan_ok", ok, 0);
        ok = model_body(64'd0, $realtobits(-240.0), px, py);
        check("pin_offy_ok", ok, 0);
        ok = model_body($realtobits(319.0), $realtobits(-239.5), px, py);
        check("pin_edge_ok", ok, 1); check("pin_edge_px", px, 639); check("pin_edge_py", py, 479);

        // Centre point and latency
        ready_mode = 0;
        load_scan(1);
        dc = done_count;
        do_start(1);
        wait_done(dc + 1, 40);
        check("centre_latency", first_valid_edge - t_start, 4);
        check("centre_done_gap", done_edge - first_valid_edge, 2);
        check("centre_idx", f_idx, 0);
        check("centre_px", f_px, 320);
        check("centre_py", f_py, 240);
        check("centre_last", f_last, 1);
        check("centre_drop", drop_count, 0);

        // Truncation and sign
        mem_x[0] = 64'hC05932CCCCCCCCCD; mem_y[0] = $realtobits(50.9);
        mem_x[1] = 64'h8000000000000000; mem_y[1] = $realtobits(239.99);
        load_scan(2);
        dc = done_count;
        do_start(2);
        wait_done(dc + 1, 60);
        check("trunc_px", f_px, 220);
        check("trunc_py", f_py, 190);
        check("trunc_hs", hs_count, 2);

        // Drop rules
        for (int i = 0; i < 4; i++) begin mem_x[i] = '0; mem_y[i] = '0; end
        mem_x[0] = $realtobits(400.0);
        mem_x[1] = 64'h7FF8000000000000;
        mem_y[2] = $realtobits(-240.0);
        mem_x[3] = $realtobits(319.0); mem_y[3] = $realtobits(-239.5);
        load_scan(4);
        dc = done_count;
        do_start(4);
        wait_done(dc + 1, 80);
        check("drop_idx", f_idx, 3);
        check("drop_px", f_px, 639);
        check("drop_py", f_py, 479);
        check("drop_last", f_last, 1);
        check("drop_cnt", drop_count, 3);
        check("drop_hs", hs_count, 1);

        // Backpressure
        mem_x[0] = $realtobits(10.5);   mem_y[0] = $realtobits(-3.2);
        mem_x[1] = $realtobits(-300.1); mem_y[1] = $realtobits(100.0);
        mem_x[2] = 64'd0;               mem_y[2] = 64'd0;
        ready_mode = 2;
        load_scan(3);
        dc = done_count;
        do_start(3);
        wait_done(dc + 1, 120);
        check("bp_hs", hs_count, 3);

        // Zero-length scan
        ready_mode = 0;
        load_scan(0);
        dc = done_count;
        do_start(0);
        wait_done(dc + 1, 20);
        check("zero_done_gap", done_edge - t_start, 2);
        check("zero_no_valid", first_valid_edge, -1);

        // Start while busy is ignored
        load_scan(3);
        dc = done_count;
        do_start(3);
        @(posedge clk); #1;
        start = 1'b1; num_bodies = AW'(1);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(dc + 1, 80);
        repeat (20) @(posedge clk);
        #1;
        check("busy_start_dones", done_count - dc, 1);
        check("busy_start_hs", hs_count, 3);

        // Reset mid-scan during EMIT of body 1
        for (int i = 0; i < 4; i++) begin
            mem_x[i] = $realtobits(real'(i * 10));
            mem_y[i] = $realtobits(real'(-i * 7));
        end
        ready_mode = 2;
        load_scan(4);
        do_start(4);
        found = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (rec_if.out_valid && rec_if.out_idx == 1) begin
                found = 1;
                break;
            end
        end
        check("rst_emit_found", found, 1);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid", rec_if.out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        rst       = 1'b0;
        prev_v    = 0;
        prev_done = 0;
        exp_q.delete();
        dc = done_count;
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_done", done_count - dc, 0);
        ready_mode = 0;
        load_scan(4);
        dc = done_count;
        do_start(4);
        wait_done(dc + 1, 80);
        check("restart_idx", f_idx, 0);
        check("restart_hs", hs_count, 4);

        // Randomised scans
        ready_mode = 1;
        for (int s = 0; s < 8; s++) begin
            n = int'($urandom_range(1, 24));
            for (int i = 0; i < n; i++) begin
                mem_x[i] = rand_coord(1'b1);
                mem_y[i] = rand_coord(1'b0);
            end
            load_scan(n);
            dc = done_count;
            do_start(n);
            wait_done(dc + 1, n * 60 + 60);
            check("rand_hs", hs_count, exp_count);
        end

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
